// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared types and constants for the fetch sequencer
// Contents: state_t (RUN, MD_WAIT, HALTED), PC_INCR, DEFAULT_RESET_VECTOR,
//           ctrl_t pipeline control bundle.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  localparam int          PC_INCR              = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - request/control bundle between hazard logic and fetch sequencer
// Signals: PCCurrent, JumpReq/JumpTarget, BranchTaken/BranchTarget, LoadUseHazard,
//          MulDivStart, HaltReq (requests); NextAddress, PC_Write, IFID_Write, IDEX_Write,
//          IFID_Flush, IDEX_Flush, Halted (controls).
// Optional macro FETCH_PERF_CNT_EN adds StallCycles and RedirectCount.
// Modports: master = hazard/branch side, slave = sequencer.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] PCCurrent;
  logic              JumpReq;
  logic [ADDR_W-1:0] JumpTarget;
  logic              BranchTaken;
  logic [ADDR_W-1:0] BranchTarget;
  logic              LoadUseHazard;
  logic              MulDivStart;
  logic              HaltReq;
  logic [ADDR_W-1:0] NextAddress;
  logic              PC_Write;
  logic              IFID_Write;
  logic              IDEX_Write;
  logic              IFID_Flush;
  logic              IDEX_Flush;
  logic              Halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       StallCycles;
  logic [31:0]       RedirectCount;

  modport master (
    output PCCurrent, JumpReq, JumpTarget, BranchTaken, BranchTarget,
           LoadUseHazard, MulDivStart, HaltReq,
    input  NextAddress, PC_Write, IFID_Write, IDEX_Write, IFID_Flush,
           IDEX_Flush, Halted, StallCycles, RedirectCount
  );

  modport slave (
    input  PCCurrent, JumpReq, JumpTarget, BranchTaken, BranchTarget,
           LoadUseHazard, MulDivStart, HaltReq,
    output NextAddress, PC_Write, IFID_Write, IDEX_Write, IFID_Flush,
           IDEX_Flush, Halted, StallCycles, RedirectCount
  );
`else
  modport master (
    output PCCurrent, JumpReq, JumpTarget, BranchTaken, BranchTarget,
           LoadUseHazard, MulDivStart, HaltReq,
    input  NextAddress, PC_Write, IFID_Write, IDEX_Write, IFID_Flush,
           IDEX_Flush, Halted
  );

  modport slave (
    input  PCCurrent, JumpReq, JumpTarget, BranchTaken, BranchTarget,
           LoadUseHazard, MulDivStart, HaltReq,
    output NextAddress, PC_Write, IFID_Write, IDEX_Write, IFID_Flush,
           IDEX_Flush, Halted
  );
`endif

endinterface

// File: rtl/fetch_sequencer_md_stall_counter.sv
// rtl/fetch_sequencer_md_stall_counter.sv - loadable down-counter with zero flag for mul/div stalls
// Ports: Clk, Reset (async, active-high), load, load_value, dec, count, zero.
// load has priority over dec; the counter saturates at zero.
module md_stall_counter #(
  parameter int WIDTH = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - next-PC selection and front-end stall/flush sequencing
// Ports: Clk, Reset (async, active-high), bus (fetch_sequencer_if.slave).
// Optional macro FETCH_PERF_CNT_EN adds StallCycles/RedirectCount counters.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter int              MD_LATENCY   = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR)
) (
  input  logic Clk,
  input  logic Reset,
  fetch_sequencer_if.slave bus
);

  localparam int CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  state_t            state_q, state_d;
  ctrl_t             ctrl;
  logic              halted;
  logic              md_load, md_dec, md_zero, md_done;
  logic [CNT_W-1:0]  md_count;
  logic [ADDR_W-1:0] next_addr;

  md_stall_counter #(.WIDTH(CNT_W)) u_md_cnt (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (md_load),
    .load_value (CNT_W'(MD_LATENCY - 2)),
    .dec        (md_dec),
    .count      (md_count),
    .zero       (md_zero)
  );

  // The counter holds the MD_WAIT cycles still to go, including the current
  // one, so the last wait cycle is the one where it reads 1 (it hits 0 as
  // RUN resumes). Together with the start cycle this gives MD_LATENCY-1 stalls.
  assign md_done = md_zero || (md_count == CNT_W'(1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    md_load = 1'b0;
    md_dec  = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.BranchTaken) begin
          ctrl.pc_write   = 1'b1;
          ctrl.ifid_flush = 1'b1;
          ctrl.idex_flush = 1'b1;
        end else if (bus.MulDivStart) begin
          md_load = 1'b1;
          // With a two-cycle unit the start cycle is the whole stall.
          if (MD_LATENCY > 2) state_d = MD_WAIT;
        end else if (bus.LoadUseHazard) begin
          ctrl.idex_flush = 1'b1;
        end else if (bus.HaltReq) begin
          ctrl.idex_write = 1'b1;
          ctrl.ifid_flush = 1'b1;
          state_d         = HALTED;
        end else if (bus.JumpReq) begin
          ctrl.pc_write   = 1'b1;
          ctrl.idex_write = 1'b1;
          ctrl.ifid_flush = 1'b1;
        end else begin
          ctrl.pc_write   = 1'b1;
          ctrl.ifid_write = 1'b1;
          ctrl.idex_write = 1'b1;
        end
      end
      MD_WAIT: begin
        md_dec = 1'b1;
        if (md_done) state_d = RUN;
      end
      HALTED: begin
        ctrl.idex_write = 1'b1;
        ctrl.ifid_flush = 1'b1;
        ctrl.idex_flush = 1'b1;
        halted          = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (Reset) begin
      ctrl            = '0;
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
      halted          = 1'b0;
      state_d         = RUN;
    end
  end

  always_comb begin
    if (Reset)                next_addr = RESET_VECTOR;
    else if (bus.BranchTaken) next_addr = bus.BranchTarget;
    else if (bus.JumpReq)     next_addr = bus.JumpTarget;
    else                      next_addr = bus.PCCurrent + ADDR_W'(PC_INCR);
    next_addr[1:0] = 2'b00;
  end

  assign bus.NextAddress = next_addr;
  assign bus.PC_Write    = ctrl.pc_write;
  assign bus.IFID_Write  = ctrl.ifid_write;
  assign bus.IDEX_Write  = ctrl.idex_write;
  assign bus.IFID_Flush  = ctrl.ifid_flush;
  assign bus.IDEX_Flush  = ctrl.idex_flush;
  assign bus.Halted      = halted;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, redirect_count;
  logic        redirect;

  // In RUN, PC load with an IF/ID flush happens only for a branch or an
  // accepted jump.
  assign redirect = bus.BranchTaken ||
                    (state_q == RUN && ctrl.pc_write && ctrl.ifid_flush);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (!ctrl.pc_write && state_q != HALTED) stall_cycles <= stall_cycles + 32'd1;
      if (redirect) redirect_count <= redirect_count + 32'd1;
    end
  end

  assign bus.StallCycles   = stall_cycles;
  assign bus.RedirectCount = redirect_count;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
  import fetch_seq_pkg::*;

  localparam int          ADDR_W     = 32;
  localparam int          MD_LATENCY = 4;
  localparam logic [31:0] RV         = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus();

  fetch_sequencer #(
    .ADDR_W       (ADDR_W),
    .MD_LATENCY   (MD_LATENCY),
    .RESET_VECTOR (RV)
  ) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus.slave)
  );

  // ctrl bit order: {pc_write, ifid_write, idex_write, ifid_flush, idex_flush}
  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [4:0]  ctrl;
    logic [4:0]  care;
    logic        halted;
    logic [31:0] stall;
    logic [31:0] redir;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  bit          m_halted = 0;
  int          m_stall_left = 0;
  logic [31:0] m_sc = 0;
  logic [31:0] m_rc = 0;
  logic [31:0] pc = 0;
  logic [31:0] last_addr;
  logic        last_pcw;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic drive(string tag, bit rst, logic [31:0] pcv, bit br, logic [31:0] bt,
                       bit jr, logic [31:0] jt, bit lu, bit md, bit hr);
    exp_t e;
    bit   jumped = 0;
    bit   go_halt = 0;
    @(posedge clk);
    #1;
    reset             = rst;
    bus.PCCurrent     = pcv;
    bus.BranchTaken   = br;
    bus.BranchTarget  = bt;
    bus.JumpReq       = jr;
    bus.JumpTarget    = jt;
    bus.LoadUseHazard = lu;
    bus.MulDivStart   = md;
    bus.HaltReq       = hr;
    e.tag = tag;
    if (rst) begin
      m_halted = 0; m_stall_left = 0; m_sc = 0; m_rc = 0;
      e.addr = RV; e.ctrl = 5'b00011; e.care = 5'b11111;
      e.halted = 0; e.stall = 0; e.redir = 0;
    end else begin
      e.addr   = (br ? bt : (jr ? jt : pcv + 32'd4)) & 32'hFFFF_FFFC;
      e.halted = m_halted;
      e.stall  = m_sc;
      e.redir  = m_rc;
      if (m_halted) begin
        e.ctrl = 5'b00111; e.care = 5'b11111;
      end else if (m_stall_left > 0) begin
        e.ctrl = 5'b00000; e.care = 5'b11100;
        m_stall_left--;
      end else if (br) begin
        e.ctrl = 5'b10011; e.care = 5'b10011;
      end else if (md) begin
        e.ctrl = 5'b00000; e.care = 5'b11100;
        m_stall_left = MD_LATENCY - 2;
      end else if (lu) begin
        e.ctrl = 5'b00001; e.care = 5'b11001;
      end else if (hr) begin
        e.ctrl = 5'b00010; e.care = 5'b10010;
        go_halt = 1;
      end else if (jr) begin
        e.ctrl = 5'b10010; e.care = 5'b10010;
        jumped = 1;
      end else begin
        e.ctrl = 5'b11100; e.care = 5'b11111;
      end
      if (!e.ctrl[4] && !m_halted) m_sc++;
      if (br || jumped) m_rc++;
      if (go_halt) m_halted = 1;
    end
    last_addr = e.addr;
    last_pcw  = e.ctrl[4] && !rst;
    sb.push_back(e);
  endtask

  task automatic idle(string tag, logic [31:0] pcv);
    drive(tag, 0, pcv, 0, 0, 0, 0, 0, 0, 0);
  endtask

  exp_t got;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [4:0] act;
      got = sb.pop_front();
      act = {bus.PC_Write, bus.IFID_Write, bus.IDEX_Write, bus.IFID_Flush, bus.IDEX_Flush};
      check({got.tag, ".NextAddress"}, bus.NextAddress, got.addr);
      for (int i = 0; i < 5; i++)
        if (got.care[i]) check($sformatf("%s.ctrl[%0d]", got.tag, i), 32'(act[i]), 32'(got.ctrl[i]));
      check({got.tag, ".Halted"}, 32'(bus.Halted), 32'(got.halted));
`ifdef FETCH_PERF_CNT_EN
      check({got.tag, ".StallCycles"}, bus.StallCycles, got.stall);
      check({got.tag, ".RedirectCount"}, bus.RedirectCount, got.redir);
`endif
    end
  end

  initial begin
    bus.PCCurrent = 0; bus.BranchTaken = 0; bus.BranchTarget = 0; bus.JumpReq = 0;
    bus.JumpTarget = 0; bus.LoadUseHazard = 0; bus.MulDivStart = 0; bus.HaltReq = 0;

    drive("reset", 1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    drive("reset", 1, 32'h55, 1, 32'h77, 1, 32'h99, 0, 0, 0);
    idle("seq", 32'h100);
    idle("wrap", 32'hFFFF_FFFC);

    drive("loaduse", 0, 32'h200, 0, 0, 0, 0, 1, 0, 0);
    idle("lu_resume", 32'h200);

    drive("md_start", 0, 32'h300, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive("md_jump", 0, 32'h304, 0, 0, 1, 32'h9000, 0, 0, 0);
    idle("md_after", 32'h9000);

    drive("br_all", 0, 32'h400, 1, 32'h4000, 1, 32'h8000, 1, 0, 1);
    idle("br_after", 32'h4000);
    drive("br_mask", 0, 32'h4004, 1, 32'h4443, 0, 0, 0, 0, 0);
    drive("jmp_mask", 0, 32'h4440, 0, 0, 1, 32'h1235, 0, 0, 0);

    drive("halt", 0, 32'h500, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) drive("halted", 0, 32'h500, 0, 0, i[0], 32'h600, 0, 0, 1);
    drive("halt_rst", 1, 32'h500, 0, 0, 0, 0, 0, 0, 0);
    idle("post_rst", RV);

    drive("md_start2", 0, 32'h700, 0, 0, 0, 0, 0, 1, 0);
    idle("md_wait1", 32'h704);
    drive("rst_mid", 1, 32'h704, 0, 0, 0, 0, 0, 0, 0);
    idle("rst_release", RV);

    pc = RV;
    for (int n = 0; n < 1500; n++) begin
      bit rst, br, jr, lu, md, hr;
      rst = ($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 15) == 0);
      br  = (m_stall_left == 0) && ($urandom_range(0, 7) == 0);
      jr  = ($urandom_range(0, 4) == 0);
      lu  = ($urandom_range(0, 5) == 0);
      md  = ($urandom_range(0, 9) == 0);
      hr  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 31) == 0) pc = $urandom;
      drive("rand", rst, pc, br, $urandom, jr, $urandom, lu, md, hr);
      if (last_pcw || rst) pc = last_addr;
    end

    for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge clk);
    #1;
    check("drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
